// File: rtl/uart_cmd_rx_pkg.sv
// Shared constants for the debug serial command receiver: command codes,
// ASCII bytes, default bit period and the byte-to-command decode helper.
package uart_cmd_rx_pkg;

    // 27 MHz system clock / 115200 baud
    localparam int DELAY_FRAMES_DEFAULT = 234;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_FEED   = 3'd1;
    localparam logic [2:0] CMD_PLAY   = 3'd2;
    localparam logic [2:0] CMD_CLEAN  = 3'd3;
    localparam logic [2:0] CMD_SLEEP  = 3'd4;
    localparam logic [2:0] CMD_WAKE   = 3'd5;
    localparam logic [2:0] CMD_TALK   = 3'd6;
    localparam logic [2:0] CMD_STATUS = 3'd7;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_F     = 8'h46;
    localparam logic [7:0] ASCII_P     = 8'h50;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_W     = 8'h57;
    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        DEC_WAIT_CMD, DEC_WAIT_TERM, DEC_DISCARD
    } dec_state_t;

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

    // Letters match with bit 5 cleared (case-insensitive); '?' must match exactly.
    function automatic logic [2:0] cmd_decode(input logic [7:0] b);
        logic [7:0] up;
        logic [2:0] code;
        up   = b & 8'hDF;
        code = CMD_NONE;
        if (b == ASCII_QMARK)   code = CMD_STATUS;
        else if (up == ASCII_F) code = CMD_FEED;
        else if (up == ASCII_P) code = CMD_PLAY;
        else if (up == ASCII_C) code = CMD_CLEAN;
        else if (up == ASCII_S) code = CMD_SLEEP;
        else if (up == ASCII_W) code = CMD_WAKE;
        else if (up == ASCII_T) code = CMD_TALK;
        return code;
    endfunction

endpackage

// File: rtl/uart_cmd_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, armed flag and bit-timing FSM.
// DELAY_FRAMES must be at least 8.
module uart_rx_byte
    import uart_cmd_rx_pkg::*;
#(
    parameter int DELAY_FRAMES = DELAY_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err
);

    localparam int HALF_DELAY_WAIT = DELAY_FRAMES / 2;
    localparam int CNT_W = $clog2(DELAY_FRAMES);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DELAY_WAIT - 1);

    logic             r_sync1, r_sync2;
    logic [1:0]       r_prime;
    logic             r_armed;
    rx_state_t        r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid, r_frame_err;
    logic             w_line, w_cnt_clr, w_shift, w_byte_ok, w_frame_bad;

    assign w_line = r_sync2;

    // The synchroniser resets to 1, so arming waits until real line values
    // have reached r_sync2; a line held low through reset never arms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prime <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= i_uart_rx;
            r_sync2 <= r_sync1;
            r_prime <= {r_prime[0], 1'b1};
            if (r_prime[1] && w_line) r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_byte_ok   = 1'b0;
        w_frame_bad = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_clr = 1'b1;
                if (r_armed && !w_line) w_next = RX_START;
            end
            RX_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_next    = w_line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit == 3'd7) w_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (w_line) begin
                        w_byte_ok = 1'b1;
                        w_next    = RX_IDLE;
                    end else begin
                        w_frame_bad = 1'b1;
                        w_next      = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                w_cnt_clr = 1'b1;
                if (w_line) w_next = RX_IDLE;
            end
            default: w_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
            r_rx_valid  <= w_byte_ok;
            r_frame_err <= w_frame_bad;
            if (w_shift) begin
                r_shift <= {w_line, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (w_byte_ok) r_rx_data <= r_shift;
        end
    end

    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/uart_cmd_rx.sv
// Debug-link command receiver: bytes from uart_rx_byte are decoded into
// one-cycle command pulses for the pet state logic.
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int DELAY_FRAMES = DELAY_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic       cmd_err
);

    logic [7:0] w_rx_data;
    logic       w_rx_valid, w_frame_err;
    logic       w_is_term;
    logic [2:0] w_code;
    dec_state_t r_dec_state, w_dec_next;
    logic       w_fire, w_err, w_pend_load;
    logic [2:0] r_pend, r_cmd_code;
    logic       r_cmd_valid, r_cmd_err;

    uart_rx_byte #(
        .DELAY_FRAMES(DELAY_FRAMES)
    ) u_rx_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_uart_rx  (uart_rx),
        .o_rx_data  (w_rx_data),
        .o_rx_valid (w_rx_valid),
        .o_frame_err(w_frame_err)
    );

    assign w_is_term = is_term(w_rx_data);
    assign w_code    = cmd_decode(w_rx_data);

    // A line is one letter then CR/LF; anything else poisons it until CR/LF.
    always_comb begin
        w_dec_next  = r_dec_state;
        w_fire      = 1'b0;
        w_err       = 1'b0;
        w_pend_load = 1'b0;
        case (r_dec_state)
            DEC_WAIT_CMD: begin
                if (w_frame_err) begin
                    w_err      = 1'b1;
                    w_dec_next = DEC_DISCARD;
                end else if (w_rx_valid && !w_is_term) begin
                    if (w_code != CMD_NONE) begin
                        w_pend_load = 1'b1;
                        w_dec_next  = DEC_WAIT_TERM;
                    end else begin
                        w_err      = 1'b1;
                        w_dec_next = DEC_DISCARD;
                    end
                end
            end
            DEC_WAIT_TERM: begin
                if (w_frame_err) begin
                    w_err      = 1'b1;
                    w_dec_next = DEC_DISCARD;
                end else if (w_rx_valid) begin
                    if (w_is_term) begin
                        w_fire     = 1'b1;
                        w_dec_next = DEC_WAIT_CMD;
                    end else begin
                        w_err      = 1'b1;
                        w_dec_next = DEC_DISCARD;
                    end
                end
            end
            DEC_DISCARD: begin
                if (w_rx_valid && w_is_term) w_dec_next = DEC_WAIT_CMD;
            end
            default: w_dec_next = DEC_WAIT_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_state <= DEC_WAIT_CMD;
            r_pend      <= CMD_NONE;
            r_cmd_code  <= CMD_NONE;
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_dec_state <= w_dec_next;
            r_cmd_valid <= w_fire;
            r_cmd_err   <= w_err;
            if (w_pend_load) r_pend <= w_code;
            if (w_fire) r_cmd_code <= r_pend;
        end
    end

    assign rx_data   = w_rx_data;
    assign rx_valid  = w_rx_valid;
    assign frame_err = w_frame_err;
    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_err   = r_cmd_err;

endmodule
